// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-master round-robin arbiter
// for a shared FemtoRV-style memory bus.
module mem_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [3:0]        m0_wmask,
  input  logic              m0_rstrb,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_rbusy,
  output logic              m0_wbusy,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [3:0]        m1_wmask,
  input  logic              m1_rstrb,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_rbusy,
  output logic              m1_wbusy,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  output logic [3:0]        s_wmask,
  output logic              s_rstrb,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic              s_rbusy,
  input  logic              s_wbusy,
  output logic [1:0]        grant,
  output logic              bus_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_t;

  localparam logic [DATA_W-1:0] LP_BAD =
    DATA_W'(32'hDEADBEEF);
  localparam logic [7:0] LP_TLAST =
    8'(TIMEOUT - 1);

  state_t            r_state;
  logic [1:0]        r_pend;
  logic [1:0]        r_rd;
  logic [ADDR_W-1:0] r_addr  [2];
  logic [DATA_W-1:0] r_wdata [2];
  logic [3:0]        r_wmask [2];
  logic [DATA_W-1:0] r_rdata [2];
  logic              r_own;
  logic              r_last;
  logic              r_err;
  logic [1:0]        r_grant;
  logic [7:0]        r_cnt;
  logic [ADDR_W-1:0] r_saddr;
  logic [DATA_W-1:0] r_swdata;
  logic [3:0]        r_swmask;
  logic              r_srstrb;

  logic [ADDR_W-1:0] w_in_addr  [2];
  logic [DATA_W-1:0] w_in_wdata [2];
  logic [3:0]        w_in_wmask [2];
  logic [1:0]        w_in_rstrb;
  logic [1:0]        w_req;
  logic [1:0]        w_done;
  logic              w_win;
  logic              w_busy;
  logic              w_fin;
  logic              w_tmo;

  assign w_in_addr[0]  = m0_addr;
  assign w_in_addr[1]  = m1_addr;
  assign w_in_wdata[0] = m0_wdata;
  assign w_in_wdata[1] = m1_wdata;
  assign w_in_wmask[0] = m0_wmask;
  assign w_in_wmask[1] = m1_wmask;
  assign w_in_rstrb    = {m1_rstrb, m0_rstrb};

  assign w_req[0] = m0_rstrb | (|m0_wmask);
  assign w_req[1] = m1_rstrb | (|m1_wmask);

  // both pending: pick the one not served last
  assign w_win = (r_pend[0] & r_pend[1]) ?
                 ~r_last : r_pend[1];

  assign w_busy = r_rd[r_own] ? s_rbusy : s_wbusy;
  assign w_fin  = (r_state == S_WAIT) & ~w_busy;
  assign w_tmo  = (r_state == S_WAIT) & w_busy &
                  (r_cnt == LP_TLAST);

  assign w_done[0] = (w_fin | w_tmo) & ~r_own;
  assign w_done[1] = (w_fin | w_tmo) & r_own;

  assign m0_rdata = r_rdata[0];
  assign m1_rdata = r_rdata[1];
  assign m0_rbusy = r_pend[0] & r_rd[0];
  assign m0_wbusy = r_pend[0] & ~r_rd[0];
  assign m1_rbusy = r_pend[1] & r_rd[1];
  assign m1_wbusy = r_pend[1] & ~r_rd[1];
  assign s_addr   = r_saddr;
  assign s_wdata  = r_swdata;
  assign s_wmask  = r_swmask;
  assign s_rstrb  = r_srstrb;
  assign grant    = r_grant;
  assign bus_err  = r_err;

  // latch each master's strobe; drop it if one is already pending
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pend <= '0;
      r_rd   <= '0;
      for (int i = 0; i < 2; i++) begin
        r_addr[i]  <= '0;
        r_wdata[i] <= '0;
        r_wmask[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!r_pend[i] && w_req[i]) begin
          r_pend[i]  <= 1'b1;
          r_rd[i]    <= w_in_rstrb[i];
          r_addr[i]  <= w_in_addr[i];
          r_wdata[i] <= w_in_wdata[i];
          r_wmask[i] <= w_in_wmask[i];
        end else if (w_done[i]) begin
          r_pend[i] <= 1'b0;
        end
      end
    end
  end

  // arbitrate, issue one slave access, wait for it or time out
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_own      <= 1'b0;
      r_last     <= 1'b1;
      r_err      <= 1'b0;
      r_grant    <= '0;
      r_cnt      <= '0;
      r_saddr    <= '0;
      r_swdata   <= '0;
      r_swmask   <= '0;
      r_srstrb   <= 1'b0;
      r_rdata[0] <= '0;
      r_rdata[1] <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (|r_pend) begin
            r_own    <= w_win;
            r_grant  <= w_win ? 2'b10 : 2'b01;
            r_saddr  <= r_addr[w_win];
            r_swdata <= r_wdata[w_win];
            r_srstrb <= r_rd[w_win];
            r_swmask <= r_rd[w_win] ?
                        4'b0000 : r_wmask[w_win];
            r_state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_srstrb <= 1'b0;
          r_swmask <= '0;
          r_cnt    <= '0;
          r_state  <= S_WAIT;
        end
        S_WAIT: begin
          if (w_fin || w_tmo) begin
            if (r_rd[r_own]) begin
              r_rdata[r_own] <= w_fin ?
                                s_rdata : LP_BAD;
            end
            if (w_tmo) begin
              r_err <= 1'b1;
            end
            r_last   <= r_own;
            r_grant  <= '0;
            r_saddr  <= '0;
            r_swdata <= '0;
            r_state  <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: scoreboard bench with a
// transaction-level model of the arbiter.
module tb_mem_bus_arbiter;

  localparam int TO = 6;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] m0_addr = '0, m1_addr = '0;
  logic [31:0] m0_wdata = '0, m1_wdata = '0;
  logic [3:0]  m0_wmask = '0, m1_wmask = '0;
  logic        m0_rstrb = 1'b0, m1_rstrb = 1'b0;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_rbusy, m0_wbusy;
  logic        m1_rbusy, m1_wbusy;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_wmask;
  logic        s_rstrb;
  logic [31:0] s_rdata = '0;
  logic        s_rbusy = 1'b0, s_wbusy = 1'b0;
  logic [1:0]  grant;
  logic        bus_err;

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .resetn(resetn),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wmask(m0_wmask), .m0_rstrb(m0_rstrb),
    .m0_rdata(m0_rdata), .m0_rbusy(m0_rbusy),
    .m0_wbusy(m0_wbusy),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wmask(m1_wmask), .m1_rstrb(m1_rstrb),
    .m1_rdata(m1_rdata), .m1_rbusy(m1_rbusy),
    .m1_wbusy(m1_wbusy),
    .s_addr(s_addr), .s_wdata(s_wdata),
    .s_wmask(s_wmask), .s_rstrb(s_rstrb),
    .s_rdata(s_rdata), .s_rbusy(s_rbusy),
    .s_wbusy(s_wbusy),
    .grant(grant), .bus_err(bus_err)
  );

  // one master request as the model sees it;
  // d = slave wait cycles, rdata = what the slave returns
  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  wmask;
    bit          rd;
    int          d;
    int          req;
    bit          iss;
    int          comp;
  } txn_t;

  txn_t sbq [2][$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   prev_comp = 0;
  bit   last = 1'b1;
  bit   exp_err = 1'b0;
  bit   mon_en = 1'b0;

  bit          slv_act = 1'b0;
  int          slv_c = 0, slv_d = 0;
  bit          slv_rd = 1'b0;
  logic [31:0] slv_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h",
               nm, cyc, act, exp);
    end
  endtask

  // monitor + slave model, both at the falling edge
  always @(negedge clk) begin
    bit   act, strobe, exp_is, bz, pend;
    bit   cand [2];
    int   own, w, j;
    txn_t t;
    if (!mon_en) begin
      sbq[0].delete();
      sbq[1].delete();
      last = 1'b1;
      exp_err = 1'b0;
      prev_comp = 0;
      slv_act = 1'b0;
      s_rbusy = 1'b0;
      s_wbusy = 1'b0;
    end else begin
      for (int m = 0; m < 2; m++) begin
        if (sbq[m].size() > 0 && sbq[m][0].iss &&
            sbq[m][0].comp == cyc) begin
          t = sbq[m][0];
          if (t.rd)
            chk(m == 1 ? "m1_rdata" : "m0_rdata",
                m == 1 ? m1_rdata : m0_rdata,
                t.d >= TO ? 32'hDEADBEEF : t.rdata);
          if (t.d >= TO) exp_err = 1'b1;
          prev_comp = cyc;
          void'(sbq[m].pop_front());
        end
      end
      act = 1'b0;
      own = 0;
      for (int m = 0; m < 2; m++) begin
        if (sbq[m].size() > 0 && sbq[m][0].iss) begin
          act = 1'b1;
          own = m;
        end
        cand[m] = sbq[m].size() > 0 &&
                  !sbq[m][0].iss &&
                  sbq[m][0].req + 2 <= cyc;
      end
      strobe = s_rstrb || (s_wmask != 4'h0);
      exp_is = !act && (cand[0] || cand[1]) &&
               prev_comp + 1 <= cyc;
      chk("issue_strobe", 32'(strobe), 32'(exp_is));
      if (strobe && exp_is) begin
        if (cand[0] && cand[1]) w = last ? 0 : 1;
        else w = cand[1] ? 1 : 0;
        t = sbq[w][0];
        chk("grant_issue", 32'(grant),
            w == 1 ? 32'd2 : 32'd1);
        chk("s_rstrb", 32'(s_rstrb), 32'(t.rd));
        chk("s_wmask", 32'(s_wmask),
            t.rd ? 32'd0 : 32'(t.wmask));
        t.iss = 1'b1;
        t.comp = cyc + (t.d >= TO ? TO + 1 : t.d + 2);
        sbq[w][0] = t;
        last = (w == 1);
        act = 1'b1;
        own = w;
        slv_act = 1'b1;
        slv_c = cyc;
        slv_d = t.d;
        slv_rd = t.rd;
        slv_data = t.rdata;
      end
      if (act) begin
        chk("grant", 32'(grant),
            own == 1 ? 32'd2 : 32'd1);
        chk("s_addr", s_addr, sbq[own][0].addr);
        chk("s_wdata", s_wdata, sbq[own][0].wdata);
      end else begin
        chk("grant_idle", 32'(grant), 32'd0);
        chk("s_addr_idle", s_addr, 32'd0);
        chk("s_wdata_idle", s_wdata, 32'd0);
      end
      chk("bus_err", 32'(bus_err), 32'(exp_err));
      for (int m = 0; m < 2; m++) begin
        pend = sbq[m].size() > 0 &&
               cyc > sbq[m][0].req;
        chk(m == 1 ? "m1_rbusy" : "m0_rbusy",
            32'(m == 1 ? m1_rbusy : m0_rbusy),
            32'(pend && sbq[m][0].rd));
        chk(m == 1 ? "m1_wbusy" : "m0_wbusy",
            32'(m == 1 ? m1_wbusy : m0_wbusy),
            32'(pend && !sbq[m][0].rd));
      end
      j = cyc - slv_c;
      bz = slv_act && j >= 1 && j <= slv_d;
      s_rbusy = slv_rd ? bz : 1'($urandom % 2);
      s_wbusy = slv_rd ? 1'($urandom % 2) : bz;
      s_rdata = bz ? $urandom : slv_data;
    end
  end

  function automatic txn_t mk(input bit rd,
                              input logic [31:0] a,
                              input logic [31:0] wd,
                              input logic [3:0] wm,
                              input int d,
                              input logic [31:0] rdat);
    txn_t t;
    t.addr = a;
    t.wdata = wd;
    t.wmask = wm;
    t.rd = rd;
    t.d = d;
    t.rdata = rdat;
    t.req = 0;
    t.iss = 1'b0;
    t.comp = 0;
    return t;
  endfunction

  function automatic txn_t rnd();
    bit rd;
    rd = 1'($urandom % 2);
    return mk(rd, $urandom, $urandom,
              rd ? 4'($urandom % 16)
                 : 4'($urandom_range(1, 15)),
              $urandom_range(0, 5), $urandom);
  endfunction

  task automatic put(input int m, input bit v,
                     input txn_t t);
    if (!v) return;
    if (m == 0) begin
      m0_addr = t.addr; m0_wdata = t.wdata;
      m0_wmask = t.wmask; m0_rstrb = t.rd;
    end else begin
      m1_addr = t.addr; m1_wdata = t.wdata;
      m1_wmask = t.wmask; m1_rstrb = t.rd;
    end
    if (sbq[m].size() > 0 && sbq[m][0].comp != cyc)
      return;
    t.req = cyc;
    sbq[m].push_back(t);
  endtask

  // one cycle of master activity; fields scrambled after
  task automatic drive(input bit v0, input txn_t a,
                       input bit v1, input txn_t b);
    put(0, v0, a);
    put(1, v1, b);
    @(posedge clk);
    #1;
    m0_rstrb = 1'b0; m0_wmask = '0;
    m1_rstrb = 1'b0; m1_wmask = '0;
    m0_addr = $urandom; m0_wdata = $urandom;
    m1_addr = $urandom; m1_wdata = $urandom;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input int lim);
    int k;
    k = 0;
    while ((sbq[0].size() > 0 || sbq[1].size() > 0)
           && k < lim) begin
      idle(1);
      k++;
    end
    checks++;
    if (sbq[0].size() > 0 || sbq[1].size() > 0) begin
      errors++;
      $display("FAIL drain cyc=%0d got=%0d,%0d want=0,0",
               cyc, sbq[0].size(), sbq[1].size());
    end
  endtask

  task automatic rst_chk();
    chk("rst_m0_rdata", m0_rdata, 32'd0);
    chk("rst_m1_rdata", m1_rdata, 32'd0);
    chk("rst_busy",
        32'({m0_rbusy, m0_wbusy, m1_rbusy, m1_wbusy}),
        32'd0);
    chk("rst_s_addr", s_addr, 32'd0);
    chk("rst_s_wdata", s_wdata, 32'd0);
    chk("rst_strobes", 32'({s_wmask, s_rstrb}), 32'd0);
    chk("rst_grant_err", 32'({grant, bus_err}), 32'd0);
  endtask

  txn_t nul;

  initial begin
    nul = mk(1'b0, '0, '0, '0, 0, '0);
    idle(3);
    rst_chk();
    resetn = 1'b1;
    idle(2);
    mon_en = 1'b1;

    drive(1'b1, mk(1'b1, 32'h10, 32'h0, 4'h0, 0,
                   32'h12345678), 1'b0, nul);
    drain(30);
    idle(2);

    drive(1'b1, mk(1'b1, 32'h20, 32'h0, 4'h0, 1,
                   32'hCAFEF00D),
          1'b1, mk(1'b0, 32'h00400000, 32'h41,
                   4'b0001, 1, 32'h0));
    drain(40);

    for (int r = 0; r < 3; r++) begin
      drive(1'b1, rnd(), 1'b1, rnd());
      drain(40);
    end

    drive(1'b0, nul, 1'b1,
          mk(1'b0, 32'h100, 32'h55AA, 4'hF, 5, 32'h0));
    idle(2);
    drive(1'b1, mk(1'b1, 32'h200, 32'h0, 4'h0, 0,
                   32'h0BADCAFE), 1'b0, nul);
    drain(40);

    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 100) < 30, rnd(),
            ($urandom % 100) < 30, rnd());
    end
    drain(200);

    drive(1'b1, mk(1'b1, 32'h300, 32'h0, 4'h0, 100,
                   32'h11112222), 1'b0, nul);
    drain(40);
    drive(1'b0, nul, 1'b1,
          mk(1'b0, 32'h400, 32'h77, 4'h3, 0, 32'h0));
    drain(40);

    drive(1'b0, nul, 1'b1,
          mk(1'b1, 32'h500, 32'h0, 4'h0, 100,
             32'h33334444));
    idle(4);
    mon_en = 1'b0;
    resetn = 1'b0;
    #1;
    rst_chk();
    idle(2);
    resetn = 1'b1;
    idle(2);
    mon_en = 1'b1;
    drive(1'b1, mk(1'b1, 32'h600, 32'h0, 4'h0, 0,
                   32'h89ABCDEF), 1'b0, nul);
    drain(30);
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-master arbiter that shares the single FemtoRV-style memory bus (address decoder, SPI flash, BRAM, UART, multiplier) between the CPU (master 0) and a secondary master such as a DMA or UART loader (master 1). Each master's single-cycle request strobe is latched, requests are granted round-robin, and exactly one transaction is issued on the shared slave port at a time. The block holds each master stalled through its rbusy/wbusy until the slave completes, then returns registered read data. It sits between the masters and the chip-select/read-mux logic.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 255, maximum WAIT cycles before abort (8-bit counter; valid range 1..255)
- clk  in  1  system clock, all logic on rising edge
- resetn  in  1  asynchronous, active-low reset
- mN_addr  in  ADDR_W  master N address (N = 0, 1)
- mN_wdata  in  DATA_W  master N write data
- mN_wmask  in  4  master N byte write mask; non-zero for one cycle = write request
- mN_rstrb  in  1  master N one-cycle read strobe
- mN_rdata  out  DATA_W  master N registered read data
- mN_rbusy  out  1  master N read pending
- mN_wbusy  out  1  master N write pending
- s_addr  out  ADDR_W  shared bus address
- s_wdata  out  DATA_W  shared bus write data
- s_wmask  out  4  shared bus write mask, one-cycle pulse
- s_rstrb  out  1  shared bus read strobe, one-cycle pulse
- s_rdata  in  DATA_W  slave read data, valid when s_rbusy low in WAIT
- s_rbusy  in  1  slave read busy
- s_wbusy  in  1  slave write busy
- grant  out  2  one-hot owner of current transaction, 2'b00 when idle
- bus_err  out  1  sticky timeout flag, cleared only by reset

## Operation
- Per master, a capture stage: on a rising edge where mN_rstrb=1 or mN_wmask!=0 and no request is pending for N, latch addr, wdata, wmask, type (read if rstrb, else write; rstrb wins if both), set pendN.
- A new request from master N while pendN=1 is dropped (protocol violation; no state change).
- FSM states: IDLE, ISSUE, WAIT.
- IDLE: if pend0 or pend1, select the winner; only one pending -> that one; both -> the master that was not granted last (rr pointer; reset value favours m0). Load grant, go to ISSUE.
- ISSUE (1 cycle): drive s_addr/s_wdata from the winner's latch; s_rstrb=1 for a read, s_wmask=latched mask for a write. Clear the timeout counter and go to WAIT.
- WAIT: s_addr/s_wdata are held, and the strobes are 0. When the relevant busy (s_rbusy for a read, s_wbusy for a write) is 0, complete the transaction:
  - for a read, register s_rdata into mN_rdata;
  - clear pendN, set rr pointer to N, grant=0, go to IDLE.
- Timeout: the WAIT counter increments each busy cycle. On reaching TIMEOUT:
  - for a read, mN_rdata=32'hDEADBEEF;
  - set bus_err, clear pendN, go to IDLE.
- mN_rbusy = pendN & read-type; mN_wbusy = pendN & write-type (registered, no combinational path from inputs).
- mN_rdata holds its last value between reads.
- Outside ISSUE/WAIT: s_addr/s_wdata=0, s_rstrb=0, s_wmask=0.

## Timing
- Reset (asynchronous, any state):
  - FSM=IDLE, pend0=pend1=0, rr favours m0, grant=0, bus_err=0, timeout counter=0;
  - all mN_rdata=0, all busy outputs=0, all s_* outputs=0.
- An in-flight slave transaction is abandoned on reset.
- Request strobe in cycle 0 -> pendN and busy high from cycle 1.
- Cycle 1: IDLE selects -> cycle 2: ISSUE (s_rstrb/s_wmask high).
- Cycle 3: WAIT, slave busy sampled.
- With a zero-wait slave, busy low and rdata valid in cycle 4 (4-cycle latency). Each slave wait cycle adds 1.
- Back-to-back: the other master's pending request issues 2 cycles after the previous completion edge (IDLE, then ISSUE).
- Request from N captured in the same cycle that the other master completes: accepted normally; arbitration uses the updated rr pointer.
- Masters must hold nothing after the strobe; all needed fields are latched.

## Test plan
- m0 read 0x00000010, zero-wait slave returning 0x12345678 -> s_rstrb pulse in cycle 2, m0_rbusy high cycles 1-3, m0_rdata=0x12345678 in cycle 4, grant=01 during ISSUE/WAIT.
- m0 read and m1 write (addr 0x00400000, wdata 0x41, wmask 4'b0001) in the same cycle after reset -> m0 served first, m1 write issued 2 cycles after m0 completes with s_wmask=0001, s_wdata=0x41.
- Repeated simultaneous requests from both masters, 3 rounds -> grant alternates 01,10,01,10,...; no master is served twice in a row while the other is pending.
- m1 write with s_wbusy held high 5 cycles -> m1_wbusy stays high through them and drops exactly 1 cycle after s_wbusy falls. m0 request arriving meanwhile is latched and issued afterwards.
- TIMEOUT=4, s_rbusy stuck high on an m0 read -> after 4 WAIT cycles m0_rdata=0xDEADBEEF, m0_rbusy low, bus_err=1 and stays 1; next m1 request still served.
- resetn pulsed low during WAIT of an m1 read -> all outputs immediately 0, FSM IDLE; a fresh m0 read afterwards completes with 4-cycle latency.
